// File: rtl/rd_nibble_packer_if.sv
// rd_nibble_packer_if: FIFO read-side entry bus plus packed-word valid/ready output bus
interface rd_nibble_packer_if #(
  parameter int Width   = 4,
  parameter int Nibbles = 4
);
  logic                       Rd_Empty;
  logic [Width-1:0]           Data_in;
  logic [Width*Nibbles-1:0]   Word_out;
  logic                       Word_valid;
  logic                       Word_ready;
  logic [1:0]                 Q_level;
  logic                       Overflow;
  modport slave (input Rd_Empty, Data_in, Word_ready, output Word_out, Word_valid, Q_level, Overflow);
  modport master (output Rd_Empty, Data_in, Word_ready, input Word_out, Word_valid, Q_level, Overflow);
endinterface

// File: rtl/rd_nibble_packer.sv
// rd_nibble_packer: packs self-popped FIFO entries into words behind a 2-entry valid/ready queue
module rd_nibble_packer #(
  parameter int Width   = 4,
  parameter int Nibbles = 4
) (
  input  logic                Rd_clk,
  input  logic                reset,
  rd_nibble_packer_if.slave   bus
);
  localparam int CW = $clog2(Nibbles);
  localparam int W  = Width * Nibbles;
  logic          pop_seen_q;
  logic [CW-1:0] nib_cnt_q, nib_cnt_d;
  logic [W-1:0]  sr_q, sr_d;
  logic [W-1:0]  mem_q [2];
  logic          head_q, tail_q;
  logic [1:0]    level_q, level_d;
  logic          ovf_q;
  logic          last, push, pop, accept;
  always_comb begin
    last = nib_cnt_q == CW'(Nibbles - 1);
    push = pop_seen_q & last;
    pop = (level_q != 2'd0) & bus.Word_ready;
    accept = push & ((level_q != 2'd2) | pop);
    sr_d = sr_q;
    if (pop_seen_q) sr_d[nib_cnt_q*Width +: Width] = bus.Data_in;
    nib_cnt_d = pop_seen_q ? (last ? '0 : nib_cnt_q + 1'b1) : nib_cnt_q;
    level_d = level_q + {1'b0, accept} - {1'b0, pop};
  end
  always_ff @(posedge Rd_clk) begin
    if (reset) begin
      pop_seen_q <= 1'b0;
      nib_cnt_q <= '0;
      sr_q <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      level_q <= 2'd0;
      ovf_q <= 1'b0;
    end else begin
      pop_seen_q <= ~bus.Rd_Empty;
      nib_cnt_q <= nib_cnt_d;
      sr_q <= sr_d;
      // on a full queue with a pop, tail equals head so the freed slot is reused
      if (accept) mem_q[tail_q] <= sr_d;
      tail_q <= tail_q ^ accept;
      head_q <= head_q ^ pop;
      level_q <= level_d;
      ovf_q <= ovf_q | (push & ~accept);
    end
  end
  assign bus.Word_out = mem_q[head_q];
  assign bus.Word_valid = level_q != 2'd0;
  assign bus.Q_level = level_q;
  assign bus.Overflow = ovf_q;
endmodule

// File: tb/tb_rd_nibble_packer.sv
// tb_rd_nibble_packer: directed scenarios with a minimal self-popping FIFO read-port model
module tb_rd_nibble_packer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [3:0] pend = 4'h0;
  bit have_pend = 1'b0;
  rd_nibble_packer_if #(.Width(4), .Nibbles(4)) bus ();
  rd_nibble_packer #(.Width(4), .Nibbles(4)) dut (.Rd_clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  // Data_in carries the entry popped at the previous edge, garbage otherwise
  task automatic step(input bit e, input logic [3:0] d, input bit rdy);
    @(negedge clk);
    bus.Data_in = have_pend ? pend : 4'hF;
    bus.Rd_Empty = e;
    bus.Word_ready = rdy;
    have_pend = !e;
    pend = d;
  endtask

  task automatic idle(input bit rdy);
    step(1'b1, 4'h0, rdy);
  endtask

  task automatic feed(input logic [15:0] w, input bit rdy);
    for (int i = 0; i < 4; i++) step(1'b0, w[4*i +: 4], rdy);
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    bus.Rd_Empty = 1'b1;
    bus.Word_ready = 1'b0;
    bus.Data_in = 4'h0;
    have_pend = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (bus.Word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.Word_valid); end
    checks++; if (bus.Q_level !== 2'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", bus.Q_level); end
    checks++; if (bus.Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.Overflow); end
    checks++; if (bus.Word_out !== 16'h0) begin errors++; $display("FAIL reset_word: got %h expected 0000", bus.Word_out); end
  endtask

  task automatic test_single_word;
    do_reset;
    feed(16'h4321, 1'b1);
    idle(1'b1);
    checks++; if (bus.Word_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b expected 0", bus.Word_valid); end
    idle(1'b1);
    checks++; if (bus.Word_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", bus.Word_valid); end
    checks++; if (bus.Word_out !== 16'h4321) begin errors++; $display("FAIL single_word: got %h expected 4321", bus.Word_out); end
    checks++; if (bus.Q_level !== 2'd1) begin errors++; $display("FAIL single_level1: got %0d expected 1", bus.Q_level); end
    idle(1'b1);
    checks++; if (bus.Word_valid !== 1'b0) begin errors++; $display("FAIL single_onecycle: got %b expected 0", bus.Word_valid); end
    checks++; if (bus.Q_level !== 2'd0) begin errors++; $display("FAIL single_level0: got %0d expected 0", bus.Q_level); end
  endtask

  task automatic test_gapped;
    do_reset;
    step(1'b0, 4'hA, 1'b1);
    step(1'b0, 4'hB, 1'b1);
    repeat (3) idle(1'b1);
    step(1'b0, 4'hC, 1'b1);
    step(1'b0, 4'hD, 1'b1);
    idle(1'b1);
    idle(1'b1);
    checks++; if (bus.Word_valid !== 1'b1) begin errors++; $display("FAIL gap_valid: got %b expected 1", bus.Word_valid); end
    checks++; if (bus.Word_out !== 16'hDCBA) begin errors++; $display("FAIL gap_word: got %h expected dcba", bus.Word_out); end
  endtask

  task automatic test_stall_drain;
    do_reset;
    feed(16'h3210, 1'b0);
    feed(16'h7654, 1'b0);
    idle(1'b0);
    idle(1'b0);
    checks++; if (bus.Q_level !== 2'd2) begin errors++; $display("FAIL stall_level: got %0d expected 2", bus.Q_level); end
    checks++; if (bus.Overflow !== 1'b0) begin errors++; $display("FAIL stall_ovf: got %b expected 0", bus.Overflow); end
    checks++; if (bus.Word_out !== 16'h3210) begin errors++; $display("FAIL stall_hold: got %h expected 3210", bus.Word_out); end
    idle(1'b1);
    checks++; if (bus.Word_out !== 16'h3210) begin errors++; $display("FAIL drain_first: got %h expected 3210", bus.Word_out); end
    idle(1'b1);
    checks++; if (bus.Word_out !== 16'h7654) begin errors++; $display("FAIL drain_second: got %h expected 7654", bus.Word_out); end
    checks++; if (bus.Q_level !== 2'd1) begin errors++; $display("FAIL drain_level1: got %0d expected 1", bus.Q_level); end
    idle(1'b0);
    checks++; if (bus.Word_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", bus.Word_valid); end
  endtask

  task automatic test_overflow;
    do_reset;
    feed(16'h3210, 1'b0);
    feed(16'h7654, 1'b0);
    feed(16'hBA98, 1'b0);
    idle(1'b0);
    idle(1'b0);
    checks++; if (bus.Overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", bus.Overflow); end
    checks++; if (bus.Q_level !== 2'd2) begin errors++; $display("FAIL ovf_level: got %0d expected 2", bus.Q_level); end
    idle(1'b1);
    checks++; if (bus.Word_out !== 16'h3210) begin errors++; $display("FAIL ovf_first: got %h expected 3210", bus.Word_out); end
    idle(1'b1);
    checks++; if (bus.Word_out !== 16'h7654) begin errors++; $display("FAIL ovf_second: got %h expected 7654", bus.Word_out); end
    idle(1'b0);
    checks++; if (bus.Q_level !== 2'd0) begin errors++; $display("FAIL ovf_drained: got %0d expected 0", bus.Q_level); end
    checks++; if (bus.Overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", bus.Overflow); end
  endtask

  task automatic test_reset_mid_word;
    step(1'b0, 4'h5, 1'b1);
    step(1'b0, 4'h6, 1'b1);
    idle(1'b1);
    do_reset;
    checks++; if ({bus.Word_valid, bus.Q_level, bus.Overflow} !== 4'b0) begin errors++; $display("FAIL midrst_flags: got %b expected 0000", {bus.Word_valid, bus.Q_level, bus.Overflow}); end
    checks++; if (bus.Word_out !== 16'h0) begin errors++; $display("FAIL midrst_word0: got %h expected 0000", bus.Word_out); end
    feed(16'h4321, 1'b1);
    idle(1'b1);
    idle(1'b1);
    checks++; if (bus.Word_out !== 16'h4321) begin errors++; $display("FAIL midrst_word: got %h expected 4321", bus.Word_out); end
    checks++; if (bus.Word_valid !== 1'b1) begin errors++; $display("FAIL midrst_valid: got %b expected 1", bus.Word_valid); end
  endtask

  task automatic test_push_pop_full;
    do_reset;
    feed(16'h3210, 1'b0);
    feed(16'h7654, 1'b0);
    feed(16'hFEDC, 1'b0);
    idle(1'b1);
    checks++; if (bus.Q_level !== 2'd2) begin errors++; $display("FAIL full_pre_level: got %0d expected 2", bus.Q_level); end
    idle(1'b1);
    checks++; if (bus.Q_level !== 2'd2) begin errors++; $display("FAIL full_level: got %0d expected 2", bus.Q_level); end
    checks++; if (bus.Overflow !== 1'b0) begin errors++; $display("FAIL full_ovf: got %b expected 0", bus.Overflow); end
    checks++; if (bus.Word_out !== 16'h7654) begin errors++; $display("FAIL full_second: got %h expected 7654", bus.Word_out); end
    idle(1'b1);
    checks++; if (bus.Word_out !== 16'hFEDC) begin errors++; $display("FAIL full_third: got %h expected fedc", bus.Word_out); end
    idle(1'b0);
    checks++; if (bus.Q_level !== 2'd0) begin errors++; $display("FAIL full_drained: got %0d expected 0", bus.Q_level); end
  endtask

  initial begin
    bus.Rd_Empty = 1'b1;
    bus.Data_in = 4'h0;
    bus.Word_ready = 1'b0;
    test_reset;
    test_single_word;
    test_gapped;
    test_stall_drain;
    test_overflow;
    test_reset_mid_word;
    test_push_pop_full;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
